// File: rtl/daq_packet_buffer_if.sv
// rtl/daq_packet_buffer_if.sv - sample stream and byte-FIFO drain signals of the DAQ packet buffer
//
// Groups the two handshake paths of daq_packet_buffer:
//   sample_valid / sample_data / sample_ready      : DAQ sample stream into the buffer
//   fifo_read_en / fifo_data / fifo_count /
//   fifo_payload_len                               : byte FIFO drained by the UDP core
// Modports:
//   master : the DAQ source and FIFO consumer side
//   slave  : the packet buffer itself
// DEPTH_LOG2 must match the DEPTH_LOG2 of the connected daq_packet_buffer.

interface daq_packet_buffer_if #(
    parameter int DEPTH_LOG2 = 12
);
    logic                  sample_valid;
    logic [15:0]           sample_data;
    logic                  sample_ready;

    logic                  fifo_read_en;
    logic [7:0]            fifo_data;
    logic [DEPTH_LOG2:0]   fifo_count;
    logic [15:0]           fifo_payload_len;

    modport master (
        output sample_valid,
        output sample_data,
        input  sample_ready,
        output fifo_read_en,
        input  fifo_data,
        input  fifo_count,
        input  fifo_payload_len
    );

    modport slave (
        input  sample_valid,
        input  sample_data,
        output sample_ready,
        input  fifo_read_en,
        output fifo_data,
        output fifo_count,
        output fifo_payload_len
    );
endinterface

// File: rtl/daq_packet_buffer.sv
// rtl/daq_packet_buffer.sv - packs 16-bit DAQ samples into framed byte packets in a circular byte buffer
//
// Purpose:
//   Builds frames of MAGIC, flags, 32-bit sequence number, 16-bit sample count,
//   the samples (all big-endian) and, optionally, a 16-bit checksum trailer.
//   Bytes become visible to the consumer only once the whole frame is committed.
//
// Optional feature:
//   DAQ_PACKET_CHECKSUM_EN - when defined, a ones-complement sum over the sample
//   words is appended inverted as a 2-byte trailer and flags bit0 is set.
//
// Ports:
//   clock        in   sole clock
//   reset        in   synchronous, active-high
//   enable       in   permits new frames to start
//   frame_start  in   one-cycle frame request
//   frame_words  in   sample count N, latched on an accepted frame_start
//   frame_busy   out  frame assembly in progress
//   drop_count   out  rejected frame_starts, saturating
//   seq_num      out  sequence number of the next frame
//   bus          slave modport: sample stream in, byte FIFO out

module daq_packet_buffer #(
    parameter logic [7:0] MAGIC      = 8'h5A,
    parameter int         MAX_WORDS  = 1024,
    parameter int         DEPTH_LOG2 = 12
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                frame_start,
    input  logic [10:0]         frame_words,
    output logic                frame_busy,
    output logic [15:0]         drop_count,
    output logic [31:0]         seq_num,
    daq_packet_buffer_if.slave  bus
);

    localparam int PW    = DEPTH_LOG2 + 1;
    localparam int DEPTH = 1 << DEPTH_LOG2;

`ifdef DAQ_PACKET_CHECKSUM_EN
    localparam logic [7:0] FLAGS   = 8'h01;
    localparam int         TRAILER = 2;
`else
    localparam logic [7:0] FLAGS   = 8'h00;
    localparam int         TRAILER = 0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_HEADER,
        S_SAMPLE_HI,
        S_SAMPLE_LO,
`ifdef DAQ_PACKET_CHECKSUM_EN
        S_CSUM_HI,
        S_CSUM_LO,
`endif
        S_COMMIT
    } state_t;

    // Frame length in bytes for a sample count n.
    function automatic logic [15:0] frame_len(input logic [10:0] n);
        return 16'(8 + TRAILER) + {4'b0000, n, 1'b0};
    endfunction

`ifdef DAQ_PACKET_CHECKSUM_EN
    // Ones-complement 16-bit add: the carry out folds back into bit 0.
    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[15:0] + {15'b0, s[16]};
    endfunction
`endif

    state_t          state_q, state_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [2:0]      hdr_idx_q, hdr_idx_d;
    logic [10:0]     words_q, words_d;
    logic [10:0]     remain_q, remain_d;
    logic [7:0]      lo_byte_q, lo_byte_d;
    logic [15:0]     drop_q, drop_d;
    logic [31:0]     seq_q, seq_d;
    logic [15:0]     payload_len_q, payload_len_d;
    logic [7:0]      fifo_data_q;
`ifdef DAQ_PACKET_CHECKSUM_EN
    logic [7:0]      hi_byte_q, hi_byte_d;
    logic [15:0]     csum_q, csum_d;
`endif

    logic [7:0]      buf_mem [DEPTH];

    logic            wr_en;
    logic [7:0]      wr_byte;
    logic            rd_en;
    logic            drop_inc;
    logic [7:0]      hdr_byte;
    logic [PW-1:0]   used_bytes;
    logic [31:0]     free_bytes;
    logic [15:0]     req_len;
    logic            req_ok;

    // Space is reserved once per frame against rd_ptr, so the writer can never
    // lap the reader even though uncommitted bytes are invisible to it.
    assign used_bytes = wr_ptr_q - rd_ptr_q;
    assign free_bytes = 32'(DEPTH) - 32'(used_bytes);
    assign req_len    = frame_len(frame_words);
    assign req_ok     = (frame_words != 11'd0)
                     && ({21'b0, frame_words} <= 32'(MAX_WORDS))
                     && (free_bytes >= {16'b0, req_len});

    // Reads only ever see committed bytes.
    assign rd_en = bus.fifo_read_en && (commit_ptr_q != rd_ptr_q);

    always_comb begin
        hdr_byte = words_q[7:0];
        case (hdr_idx_q)
            3'd0:    hdr_byte = MAGIC;
            3'd1:    hdr_byte = FLAGS;
            3'd2:    hdr_byte = seq_q[31:24];
            3'd3:    hdr_byte = seq_q[23:16];
            3'd4:    hdr_byte = seq_q[15:8];
            3'd5:    hdr_byte = seq_q[7:0];
            3'd6:    hdr_byte = {5'b0, words_q[10:8]};
            default: hdr_byte = words_q[7:0];
        endcase
    end

    always_comb begin
        state_d       = state_q;
        hdr_idx_d     = hdr_idx_q;
        words_d       = words_q;
        remain_d      = remain_q;
        lo_byte_d     = lo_byte_q;
        commit_ptr_d  = commit_ptr_q;
        seq_d         = seq_q;
        payload_len_d = payload_len_q;
        wr_en         = 1'b0;
        wr_byte       = 8'h00;
        drop_inc      = 1'b0;
`ifdef DAQ_PACKET_CHECKSUM_EN
        hi_byte_d     = hi_byte_q;
        csum_d        = csum_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (frame_start && enable) begin
                    if (req_ok) begin
                        words_d   = frame_words;
                        remain_d  = frame_words;
                        hdr_idx_d = 3'd0;
`ifdef DAQ_PACKET_CHECKSUM_EN
                        csum_d    = 16'h0000;
`endif
                        state_d   = S_HEADER;
                    end else begin
                        drop_inc = 1'b1;
                    end
                end
            end

            S_HEADER: begin
                wr_en     = 1'b1;
                wr_byte   = hdr_byte;
                hdr_idx_d = hdr_idx_q + 3'd1;
                if (hdr_idx_q == 3'd7) begin
                    state_d = S_SAMPLE_HI;
                end
            end

            S_SAMPLE_HI: begin
                if (bus.sample_valid) begin
                    wr_en     = 1'b1;
                    wr_byte   = bus.sample_data[15:8];
                    lo_byte_d = bus.sample_data[7:0];
`ifdef DAQ_PACKET_CHECKSUM_EN
                    hi_byte_d = bus.sample_data[15:8];
`endif
                    state_d   = S_SAMPLE_LO;
                end
            end

            S_SAMPLE_LO: begin
                wr_en    = 1'b1;
                wr_byte  = lo_byte_q;
                remain_d = remain_q - 11'd1;
`ifdef DAQ_PACKET_CHECKSUM_EN
                csum_d   = ones_add(csum_q, {hi_byte_q, lo_byte_q});
`endif
                if (remain_q == 11'd1) begin
`ifdef DAQ_PACKET_CHECKSUM_EN
                    state_d = S_CSUM_HI;
`else
                    state_d = S_COMMIT;
`endif
                end else begin
                    state_d = S_SAMPLE_HI;
                end
            end

`ifdef DAQ_PACKET_CHECKSUM_EN
            S_CSUM_HI: begin
                wr_en   = 1'b1;
                wr_byte = ~csum_q[15:8];
                state_d = S_CSUM_LO;
            end

            S_CSUM_LO: begin
                wr_en   = 1'b1;
                wr_byte = ~csum_q[7:0];
                state_d = S_COMMIT;
            end
`endif

            S_COMMIT: begin
                commit_ptr_d  = wr_ptr_q;
                payload_len_d = frame_len(words_q);
                seq_d         = seq_q + 32'd1;
                state_d       = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A request while a frame is being assembled is dropped regardless of enable.
        if (frame_start && (state_q != S_IDLE)) begin
            drop_inc = 1'b1;
        end
    end

    assign wr_ptr_d = wr_en ? (wr_ptr_q + 1'b1) : wr_ptr_q;
    assign rd_ptr_d = rd_en ? (rd_ptr_q + 1'b1) : rd_ptr_q;
    assign drop_d   = (drop_inc && (drop_q != 16'hFFFF)) ? (drop_q + 16'd1) : drop_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            commit_ptr_q  <= '0;
            rd_ptr_q      <= '0;
            hdr_idx_q     <= 3'd0;
            words_q       <= 11'd0;
            remain_q      <= 11'd0;
            lo_byte_q     <= 8'h00;
            drop_q        <= 16'h0000;
            seq_q         <= 32'h0;
            payload_len_q <= 16'h0000;
            fifo_data_q   <= 8'h00;
`ifdef DAQ_PACKET_CHECKSUM_EN
            hi_byte_q     <= 8'h00;
            csum_q        <= 16'h0000;
`endif
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            commit_ptr_q  <= commit_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            hdr_idx_q     <= hdr_idx_d;
            words_q       <= words_d;
            remain_q      <= remain_d;
            lo_byte_q     <= lo_byte_d;
            drop_q        <= drop_d;
            seq_q         <= seq_d;
            payload_len_q <= payload_len_d;
            if (rd_en) begin
                fifo_data_q <= buf_mem[rd_ptr_q[DEPTH_LOG2-1:0]];
            end
`ifdef DAQ_PACKET_CHECKSUM_EN
            hi_byte_q     <= hi_byte_d;
            csum_q        <= csum_d;
`endif
        end
    end

    // Buffer storage carries no reset; discarded bytes are simply unreachable
    // once the pointers return to zero.
    always_ff @(posedge clock) begin
        if (wr_en && !reset) begin
            buf_mem[wr_ptr_q[DEPTH_LOG2-1:0]] <= wr_byte;
        end
    end

    assign bus.sample_ready     = (state_q == S_SAMPLE_HI);
    assign bus.fifo_data        = fifo_data_q;
    assign bus.fifo_count       = commit_ptr_q - rd_ptr_q;
    assign bus.fifo_payload_len = payload_len_q;
    assign frame_busy           = (state_q != S_IDLE);
    assign drop_count           = drop_q;
    assign seq_num              = seq_q;

endmodule

// File: tb/tb_daq_packet_buffer.sv
// tb/tb_daq_packet_buffer.sv - scoreboard bench for daq_packet_buffer with a frame-level reference model
`timescale 1ns/1ps

module tb_daq_packet_buffer;

`ifdef DAQ_PACKET_CHECKSUM_EN
    localparam int         TRAIL = 2;
    localparam logic [7:0] FLAGS = 8'h01;
`else
    localparam int         TRAIL = 0;
    localparam logic [7:0] FLAGS = 8'h00;
`endif
    localparam int BUF_BYTES = 4096;
    localparam int MAXW      = 1024;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        frame_start = 1'b0;
    logic [10:0] frame_words = 11'd0;
    logic        frame_busy;
    logic [15:0] drop_count;
    logic [31:0] seq_num;

    daq_packet_buffer_if #(.DEPTH_LOG2(12)) bus ();

    daq_packet_buffer #(.MAGIC(8'h5A), .MAX_WORDS(1024), .DEPTH_LOG2(12)) dut (
        .clock       (clock),
        .reset       (reset),
        .enable      (enable),
        .frame_start (frame_start),
        .frame_words (frame_words),
        .frame_busy  (frame_busy),
        .drop_count  (drop_count),
        .seq_num     (seq_num),
        .bus         (bus)
    );

    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    logic [15:0] smp_q[$];
    int          mdl_seq = 0;
    int          mdl_drop = 0;
    int          rd_mode = 0;
    int          cnt_last_busy = 0;
    int          cnt_after = 0;
    logic [7:0]  last_byte = 8'h00;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic abort_run(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for the DUT", name);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "stopped");
    endtask

    function automatic int flen(input int n);
        return 8 + 2 * n + TRAIL;
    endfunction

    // Expected frame bytes, built straight from the frame layout rules.
    task automatic push_frame(input int n, input int seq);
        int sum;
        int cs;
        exp_q.push_back(8'h5A);
        exp_q.push_back(FLAGS);
        exp_q.push_back(8'((seq >> 24) & 255));
        exp_q.push_back(8'((seq >> 16) & 255));
        exp_q.push_back(8'((seq >> 8) & 255));
        exp_q.push_back(8'(seq & 255));
        exp_q.push_back(8'((n >> 8) & 255));
        exp_q.push_back(8'(n & 255));
        sum = 0;
        foreach (smp_q[i]) begin
            exp_q.push_back(smp_q[i][15:8]);
            exp_q.push_back(smp_q[i][7:0]);
            sum = sum + int'(smp_q[i]);
            if (sum > 'hFFFF) sum = sum - 'h10000 + 1;
        end
        cs = (~sum) & 'hFFFF;
        if (TRAIL == 2) begin
            exp_q.push_back(8'((cs >> 8) & 255));
            exp_q.push_back(8'(cs & 255));
        end
    endtask

    // Requests one frame; the model decides acceptance from the length/space rules.
    task automatic send_frame(input int n, input bit extra_start, input int gapmax, input bit preset);
        int  len;
        bit  accept;
        int  t;
        len    = flen(n);
        accept = (n != 0) && (n <= MAXW) && ((BUF_BYTES - exp_q.size()) >= len);
        @(negedge clock);
        frame_start = 1'b1;
        frame_words = 11'(n);
        enable      = 1'b1;
        @(negedge clock);
        frame_start = 1'b0;
        if (!accept) begin
            mdl_drop++;
            chk("drop_on_reject", drop_count, mdl_drop);
            chk("idle_after_reject", frame_busy, 0);
            chk("seq_after_reject", seq_num, mdl_seq);
            return;
        end
        chk("busy_on_accept", frame_busy, 1);
        if (!preset) begin
            smp_q.delete();
            for (int i = 0; i < n; i++) smp_q.push_back(16'($urandom));
        end
        push_frame(n, mdl_seq);
        if (extra_start) begin
            frame_start = 1'b1;
            @(negedge clock);
            frame_start = 1'b0;
            mdl_drop++;
            chk("drop_while_busy", drop_count, mdl_drop);
        end
        enable = 1'($urandom);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(gapmax, 0)) @(negedge clock);
            bus.sample_valid = 1'b1;
            bus.sample_data  = smp_q[i];
            t = 0;
            do begin
                @(posedge clock);
                t++;
            end while (!bus.sample_ready && t < 64);
            if (!bus.sample_ready) abort_run("sample_ready");
            @(negedge clock);
            bus.sample_valid = 1'b0;
        end
        t = 0;
        while (frame_busy && t < 16) begin
            cnt_last_busy = int'(bus.fifo_count);
            @(negedge clock);
            t++;
        end
        if (frame_busy) abort_run("frame_end");
        cnt_after = int'(bus.fifo_count);
        enable    = 1'b1;
        mdl_seq++;
        chk("seq_num", seq_num, mdl_seq);
        chk("payload_len", bus.fifo_payload_len, len);
    endtask

    task automatic drain();
        int t;
        t = 0;
        rd_mode = 1;
        while (exp_q.size() != 0 && t < 20000) begin
            @(negedge clock);
            t++;
        end
        rd_mode = 0;
        repeat (3) @(negedge clock);
        if (t >= 20000) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d bytes never delivered", exp_q.size());
        end
        chk("drained_count", bus.fifo_count, 0);
    endtask

    // Consumer: read pattern chosen by rd_mode (0 off, 1 random, 2 every cycle).
    initial begin
        bus.fifo_read_en = 1'b0;
        forever begin
            @(negedge clock);
            case (rd_mode)
                0:       bus.fifo_read_en = 1'b0;
                1:       bus.fifo_read_en = 1'($urandom);
                default: bus.fifo_read_en = 1'b1;
            endcase
        end
    end

    // Monitor: every effective pop is compared one cycle later against the scoreboard.
    initial begin
        logic [7:0] b;
        forever begin
            @(posedge clock);
            if (!reset && bus.fifo_read_en && bus.fifo_count != 0) begin
                @(negedge clock);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_underflow: got byte %02h with none expected", bus.fifo_data);
                end else begin
                    b = exp_q.pop_front();
                    chk("fifo_data", bus.fifo_data, b);
                    last_byte = b;
                end
            end
        end
    end

    initial begin
        #900000;
        abort_run("watchdog");
    end

    initial begin
        int total;
        bus.sample_valid = 1'b0;
        bus.sample_data  = 16'h0000;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_fifo_count", bus.fifo_count, 0);
        chk("rst_payload_len", bus.fifo_payload_len, 0);
        chk("rst_frame_busy", frame_busy, 0);
        chk("rst_drop_count", drop_count, 0);
        chk("rst_seq_num", seq_num, 0);
        chk("rst_sample_ready", bus.sample_ready, 0);
        chk("rst_fifo_data", bus.fifo_data, 0);

        // Directed frame: count must stay 0 until the commit cycle.
        smp_q = {16'h1234, 16'hABCD};
        send_frame(2, 0, 0, 1);
        chk("count_before_commit", cnt_last_busy, 0);
        chk("count_after_commit", cnt_after, flen(2));
        drain();

        // Checksum end-around carry case.
        smp_q = {16'hFFFF, 16'h0001};
        send_frame(2, 0, 1, 1);
        drain();

        // Illegal sizes and a request during HEADER.
        send_frame(0, 0, 0, 0);
        send_frame(1025, 0, 0, 0);
        chk("count_after_rejects", bus.fifo_count, 0);
        send_frame(3, 1, 1, 0);
        drain();

        // frame_start with enable low is ignored and not counted.
        @(negedge clock);
        frame_start = 1'b1;
        enable      = 1'b0;
        @(negedge clock);
        frame_start = 1'b0;
        chk("disabled_start_drop", drop_count, mdl_drop);
        chk("disabled_start_idle", frame_busy, 0);
        enable = 1'b1;

        // Fill without reading: only as many max frames as fit are accepted.
        send_frame(1024, 0, 1, 0);
        send_frame(1024, 0, 1, 0);
        send_frame(1024, 0, 1, 0);
        chk("fill_count", bus.fifo_count, flen(1024));
        drain();
        send_frame(1024, 0, 1, 0);
        drain();

        // Commit landing on a cycle that also pops.
        send_frame(200, 0, 0, 0);
        rd_mode = 2;
        send_frame(5, 0, 0, 0);
        chk("count_commit_with_read", cnt_after, cnt_last_busy + flen(5) - 1);

        // Streaming with continuous reads, pointers wrap repeatedly.
        total = 0;
        while (total < 4600) begin
            int n;
            n = int'($urandom_range(120, 1));
            send_frame(n, 0, 2, 0);
            total += flen(n);
        end
        drain();

        // Reading an empty FIFO holds the last byte.
        rd_mode = 2;
        repeat (4) @(negedge clock);
        rd_mode = 0;
        @(negedge clock);
        chk("empty_read_hold", bus.fifo_data, last_byte);
        chk("empty_read_count", bus.fifo_count, 0);

        // Reset while a frame sits in SAMPLE_LO with committed bytes pending.
        send_frame(3, 0, 0, 0);
        @(negedge clock);
        frame_start = 1'b1;
        frame_words = 11'd4;
        @(negedge clock);
        frame_start = 1'b0;
        bus.sample_valid = 1'b1;
        bus.sample_data  = 16'hBEEF;
        begin
            int t;
            t = 0;
            do begin
                @(posedge clock);
                t++;
            end while (!bus.sample_ready && t < 64);
            if (!bus.sample_ready) abort_run("reset_sample_ready");
        end
        @(negedge clock);
        bus.sample_valid = 1'b0;
        chk("pre_reset_busy", frame_busy, 1);
        chk("pre_reset_count", bus.fifo_count, flen(3));
        reset = 1'b1;
        @(negedge clock);
        chk("mid_reset_count", bus.fifo_count, 0);
        chk("mid_reset_busy", frame_busy, 0);
        chk("mid_reset_ready", bus.sample_ready, 0);
        chk("mid_reset_seq", seq_num, 0);
        chk("mid_reset_drop", drop_count, 0);
        chk("mid_reset_payload", bus.fifo_payload_len, 0);
        exp_q.delete();
        mdl_seq  = 0;
        mdl_drop = 0;
        reset    = 1'b0;
        send_frame(2, 0, 1, 0);
        drain();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
